urd_rx_fdec_ctrl_mc: RTL
========================

// Module: urd_rx_fdec_ctrl_mc
// PURPOSE
//  Multi-channel RX frame-decode controller. Arbitrates round-robin between N_CH job-info FIFOs,
//  sequences header/PL64 readout into the shared rxl datapath, supports concatenated jobs and
//  routes pre-URD, size and header errors to the FD job queue as error jobs. Adds a programmable
//  data-starvation watchdog that aborts a stalled frame. Sits between the RX FIFO/info FIFOs and rxl.
// PARAMETERS
//  N_CH   4  number of job channels (>=2)
//  CH_W   2  channel index width, clog2(N_CH)
//  ERR_W  8  error event id width
//  TO_W   8  watchdog counter / timeout_cfg width
// PORTS
//  clk               in   1         clock
//  rst               in   1         asynchronous reset, active-high
//  job_avail         in   N_CH      per-channel job info available
//  job_err           in   3*N_CH    per-ch {hdr_err,size_err,pre_urd_err}, ch c at [3c+2:3c]
//  job_zero_pl       in   N_CH      per-ch zero-payload job (len+32==offset)
//  slot_avail        in   1         processing queue slot available
//  slot_avail_early  in   1         early slot-available indication
//  rxf_lower_dav     in   1         RX FIFO lower half data valid
//  rxf_upper_dav     in   1         RX FIFO upper half data valid
//  rxl_concat        in   1         rxl result requests concatenation
//  ev_inc_err        in   ERR_W     event id: pre-URD / incomplete error (also watchdog)
//  ev_oversize_ip    in   ERR_W     event id: oversize error
//  ev_eth_head_err   in   ERR_W     event id: ethernet header error
//  timeout_cfg       in   TO_W      watchdog limit in cycles; 0 = disabled
//  job_pop           out  N_CH      one-hot pop of granted channel's info FIFO
//  ch_sel            out  CH_W      channel currently owning the datapath (registered)
//  pl64_read         out  1         trigger PL64 read
//  hdr_read          out  1         trigger header read
//  rxl_load_lower    out  1         load lower half into rxl and trigger
//  rxl_load_upper    out  1         load upper half into rxl
//  rxf_stop          out  1         abort/flush RX FIFO readout
//  wr_job            out  1         write FD job queue
//  wr_err_job        out  1         write FD job queue, error job
//  err_id            out  ERR_W     error event id, valid when wr_err_job=1
//  timeout_evt       out  1         watchdog fired (1-cycle pulse)
// BEHAVIOUR
//  - Strobes are Mealy (state+inputs), forced 0 while rst=1. ch_sel, rr_ptr, err_q, zpl_q, wd_cnt reset 0; state->IDLE.
//  - IDLE: if slot_avail & |job_avail: grant g = first set job_avail at/after rr_ptr (wrap);
//    job_pop[g]=1, pl64_read=1, ch_sel<=g, rr_ptr<=(g+1)%N_CH, zpl_q<=job_zero_pl[g].
//    err precedence pre_urd > size > hdr: err_q<=ev_inc_err/ev_oversize_ip/ev_eth_head_err,
//    hdr_read=1, ->ERR_HDR. No error bit -> PL64. No grant: stay, no strobes.
//  - PL64: lower_dav->rxl_load_lower. upper_dav->rxl_load_upper+hdr_read, ->RXL_WAIT.
//    zpl_q=1 -> load_lower+load_upper+hdr_read same cycle, ->RXL_WAIT (dav ignored).
//  - RXL_WAIT (1 cycle): wr_job=1. !rxl_concat->IDLE; else slot_avail_early->pl64_read,
//    ->PL64_CONCAT; else ->CONCAT_WAIT. Concatenation keeps ch_sel, no arbitration, no job_pop.
//  - CONCAT_WAIT: slot_avail -> pl64_read, ->PL64_CONCAT. No watchdog here.
//  - PL64_CONCAT: lower_dav->load_lower; upper_dav->load_upper, ->RXL_WAIT. No hdr_read.
//  - ERR_HDR: lower_dav -> wr_err_job=1, err_id=err_q, ->IDLE.
//  - err_id = ev_inc_err when timeout_evt else err_q.
//  - Watchdog (PL64, PL64_CONCAT, ERR_HDR only): wd_cnt clears on state entry and on any dav;
//    else increments, saturating. If timeout_cfg!=0 & wd_cnt==timeout_cfg-1 & no dav this cycle:
//    timeout_evt=1, rxf_stop=1, wr_err_job=1, ->IDLE. wd_cnt width TO_W, never wraps.
//  - Simultaneous lower+upper dav in PL64: both loads same cycle. A dav always beats the watchdog.
//  - Async rst mid-frame: immediate return to IDLE, strobes low, no job write emitted.
// TESTING
//  1 job_avail=4'b1010, rr_ptr=0, slot_avail=1 -> job_pop=4'b0010, ch_sel=1; next grant ch3, then ch1.
//  2 Ch0 normal: lower_dav then upper_dav, concat=0 -> load_lower, load_upper+hdr_read, wr_job 1 cycle, IDLE.
//  3 Ch2 job_err=3'b110 -> err_q=ev_oversize_ip; lower_dav in ERR_HDR -> wr_err_job=1, err_id=ev_oversize_ip.
//  4 rxl_concat=1, slot_avail_early=0, slot_avail after 5 cycles -> CONCAT_WAIT 5 cycles, pl64_read, PL64_CONCAT.
//  5 timeout_cfg=8, no dav in PL64 -> 8th cycle: timeout_evt=rxf_stop=wr_err_job=1, err_id=ev_inc_err; cfg=0 never fires.
//  6 job_zero_pl=1 -> PL64 first cycle: load_lower+load_upper+hdr_read; rst pulse mid-PL64 -> IDLE, strobes 0.

Source files
------------

// File: rtl/urd_rx_fdec_ctrl_mc_if.sv
// urd_rx_fdec_ctrl_mc_if: job-info, RX FIFO, rxl and FD job queue signals of the frame-decode controller
interface urd_rx_fdec_ctrl_mc_if #(
   parameter int N_CH  = 4,
   parameter int CH_W  = 2,
   parameter int ERR_W = 8,
   parameter int TO_W  = 8
);
   logic [N_CH-1:0]   job_avail;
   logic [3*N_CH-1:0] job_err;
   logic [N_CH-1:0]   job_zero_pl;
   logic              slot_avail;
   logic              slot_avail_early;
   logic              rxf_lower_dav;
   logic              rxf_upper_dav;
   logic              rxl_concat;
   logic [ERR_W-1:0]  ev_inc_err;
   logic [ERR_W-1:0]  ev_oversize_ip;
   logic [ERR_W-1:0]  ev_eth_head_err;
   logic [TO_W-1:0]   timeout_cfg;
   logic [N_CH-1:0]   job_pop;
   logic [CH_W-1:0]   ch_sel;
   logic              pl64_read;
   logic              hdr_read;
   logic              rxl_load_lower;
   logic              rxl_load_upper;
   logic              rxf_stop;
   logic              wr_job;
   logic              wr_err_job;
   logic [ERR_W-1:0]  err_id;
   logic              timeout_evt;

   modport master (
      output job_avail, job_err, job_zero_pl, slot_avail, slot_avail_early,
             rxf_lower_dav, rxf_upper_dav, rxl_concat, ev_inc_err, ev_oversize_ip,
             ev_eth_head_err, timeout_cfg,
      input  job_pop, ch_sel, pl64_read, hdr_read, rxl_load_lower, rxl_load_upper,
             rxf_stop, wr_job, wr_err_job, err_id, timeout_evt
   );

   modport slave (
      input  job_avail, job_err, job_zero_pl, slot_avail, slot_avail_early,
             rxf_lower_dav, rxf_upper_dav, rxl_concat, ev_inc_err, ev_oversize_ip,
             ev_eth_head_err, timeout_cfg,
      output job_pop, ch_sel, pl64_read, hdr_read, rxl_load_lower, rxl_load_upper,
             rxf_stop, wr_job, wr_err_job, err_id, timeout_evt
   );
endinterface

// File: rtl/urd_rx_fdec_ctrl_mc.sv
// urd_rx_fdec_ctrl_mc: round-robin multi-channel RX frame-decode controller with starvation watchdog
module urd_rx_fdec_ctrl_mc #(
   parameter int N_CH  = 4,
   parameter int CH_W  = 2,
   parameter int ERR_W = 8,
   parameter int TO_W  = 8
) (
   input logic                   clk,
   input logic                   rst,
   urd_rx_fdec_ctrl_mc_if.slave  bus
);
   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] PL64        = 3'd1;
   localparam logic [2:0] RXL_WAIT    = 3'd2;
   localparam logic [2:0] CONCAT_WAIT = 3'd3;
   localparam logic [2:0] PL64_CONCAT = 3'd4;
   localparam logic [2:0] ERR_HDR     = 3'd5;

   logic [2:0]      state, state_nxt;
   logic [CH_W-1:0] ch_q, rr_ptr, g;
   logic [ERR_W-1:0] err_q;
   logic            zpl_q;
   logic [TO_W-1:0] wd_cnt;
   logic [CH_W:0]   pick_r;
   logic [2:0]      g_err;
   logic            grant, dav, wd_on, wd_fire;
   logic [N_CH-1:0] pop;
   logic            pl64, hdr, ld_lo, ld_up, wj, wej;

   // {valid, index} of the first available channel at or after ptr, wrapping
   function automatic logic [CH_W:0] pick(input logic [N_CH-1:0] av, input logic [CH_W-1:0] ptr);
      logic [CH_W:0] r, s;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         s = {1'b0, ptr} + (CH_W+1)'(i);
         if (s >= (CH_W+1)'(N_CH)) s = s - (CH_W+1)'(N_CH);
         if (av[s[CH_W-1:0]]) r = {1'b1, s[CH_W-1:0]};
      end
      return r;
   endfunction

   assign pick_r = pick(bus.job_avail, rr_ptr);
   assign g      = pick_r[CH_W-1:0];
   assign grant  = bus.slot_avail & pick_r[CH_W];
   assign g_err  = bus.job_err[3*int'(g) +: 3];
   assign dav    = bus.rxf_lower_dav | bus.rxf_upper_dav;
   assign wd_on  = (state == PL64 && !zpl_q) || state == PL64_CONCAT || state == ERR_HDR;
   assign wd_fire = wd_on && bus.timeout_cfg != '0 && wd_cnt == bus.timeout_cfg - TO_W'(1) && !dav;

   always_comb begin
      state_nxt = state;
      pop = '0;
      pl64 = 1'b0;
      hdr = 1'b0;
      ld_lo = 1'b0;
      ld_up = 1'b0;
      wj = 1'b0;
      wej = 1'b0;
      case (state)
         IDLE: if (grant) begin
            pop = N_CH'(1) << g;
            pl64 = 1'b1;
            hdr = |g_err;
            state_nxt = |g_err ? ERR_HDR : PL64;
         end
         PL64: begin
            ld_lo = zpl_q | bus.rxf_lower_dav;
            ld_up = zpl_q | bus.rxf_upper_dav;
            hdr = ld_up;
            state_nxt = ld_up ? RXL_WAIT : PL64;
         end
         RXL_WAIT: begin
            wj = 1'b1;
            pl64 = bus.rxl_concat & bus.slot_avail_early;
            state_nxt = !bus.rxl_concat ? IDLE : bus.slot_avail_early ? PL64_CONCAT : CONCAT_WAIT;
         end
         CONCAT_WAIT: begin
            pl64 = bus.slot_avail;
            state_nxt = bus.slot_avail ? PL64_CONCAT : CONCAT_WAIT;
         end
         PL64_CONCAT: begin
            ld_lo = bus.rxf_lower_dav;
            ld_up = bus.rxf_upper_dav;
            state_nxt = bus.rxf_upper_dav ? RXL_WAIT : PL64_CONCAT;
         end
         ERR_HDR: begin
            wej = bus.rxf_lower_dav;
            state_nxt = bus.rxf_lower_dav ? IDLE : ERR_HDR;
         end
         default: state_nxt = IDLE;
      endcase
      if (wd_fire) begin
         wej = 1'b1;
         state_nxt = IDLE;
      end
   end

   assign bus.job_pop        = rst ? '0 : pop;
   assign bus.pl64_read      = pl64 & ~rst;
   assign bus.hdr_read       = hdr & ~rst;
   assign bus.rxl_load_lower = ld_lo & ~rst;
   assign bus.rxl_load_upper = ld_up & ~rst;
   assign bus.wr_job         = wj & ~rst;
   assign bus.wr_err_job     = wej & ~rst;
   assign bus.rxf_stop       = wd_fire & ~rst;
   assign bus.timeout_evt    = wd_fire & ~rst;
   assign bus.err_id         = wd_fire ? bus.ev_inc_err : err_q;
   assign bus.ch_sel         = ch_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ch_q   <= '0;
         rr_ptr <= '0;
         err_q  <= '0;
         zpl_q  <= 1'b0;
         wd_cnt <= '0;
      end else begin
         state  <= state_nxt;
         wd_cnt <= (state_nxt != state || dav) ? '0 : &wd_cnt ? wd_cnt : wd_cnt + TO_W'(1);
         if (state == IDLE && grant) begin
            ch_q   <= g;
            rr_ptr <= (g == CH_W'(N_CH - 1)) ? '0 : g + CH_W'(1);
            zpl_q  <= bus.job_zero_pl[g];
            if (|g_err)
               err_q <= g_err[0] ? bus.ev_inc_err : g_err[1] ? bus.ev_oversize_ip : bus.ev_eth_head_err;
         end
      end
   end
endmodule
